// File: rtl/vga_pkg.sv
// Shared VGA/title definitions: visible-area size, bus widths, colour
// constants and the title blink FSM state encoding.
package vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned V_VISIBLE = 480;

  localparam int unsigned PX_W   = 10;   // pixel coordinate width
  localparam int unsigned ROW_AW = 6;    // title ROM row address width
  localparam int unsigned ROM_W  = 216;  // title ROM row word width
  localparam int unsigned RGB_W  = 8;    // RRRGGGBB
  localparam int unsigned COL_W  = 8;    // column offset inside the title box

  localparam logic [RGB_W-1:0] BLACK  = 8'h00;
  localparam logic [RGB_W-1:0] YELLOW = 8'hFC;

  typedef enum logic [1:0] {
    ST_HIDDEN = 2'd0,
    ST_SHOW   = 2'd1,
    ST_BLANK  = 2'd2
  } title_state_e;

endpackage

// File: rtl/title_renderer_if.sv
// Pixel/ROM/colour bundle between vga_sync, the title ROM and the colour mux.
//   master : drives coordinates, title_en and rom_data; observes outputs
//   slave  : the renderer (consumes coordinates, issues rom_addr, drives rgb)
interface title_renderer_if;
  import vga_pkg::*;

  logic              pixel_tick;
  logic              video_on;
  logic [PX_W-1:0]   pixel_x;
  logic [PX_W-1:0]   pixel_y;
  logic              title_en;
  logic [ROW_AW-1:0] rom_addr;
  logic [ROM_W-1:0]  rom_data;
  logic [RGB_W-1:0]  rgb;
  logic              title_pix;
  logic              blank_phase;

  modport master (
    output pixel_tick, video_on, pixel_x, pixel_y, title_en, rom_data,
    input  rom_addr, rgb, title_pix, blank_phase
  );

  modport slave (
    input  pixel_tick, video_on, pixel_x, pixel_y, title_en, rom_data,
    output rom_addr, rgb, title_pix, blank_phase
  );
endinterface

// File: rtl/title_blink_fsm.sv
// Title visibility FSM (HIDDEN/SHOW/BLANK) with frame counter.
// State changes only at frame start so a frame is never torn.
//   clk, rst_n  : clock, async active-low reset
//   fs_i        : frame start strobe (already qualified by pixel_tick)
//   title_en_i  : level request to display the title
//   show_o      : registered, 1 while in SHOW
//   blank_o     : registered, 1 while in BLANK
module title_blink_fsm
  import vga_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fs_i,
  input  logic title_en_i,
  output logic show_o,
  output logic blank_o
);

  localparam int unsigned CNT_W    = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned LAST_INT = (BLINK_FRAMES == 0) ? 0 : BLINK_FRAMES - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_INT);

  title_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             show_q;
  logic             blank_q;

  // Disable has priority over a phase change at the same frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HIDDEN;
      cnt_q   <= '0;
      show_q  <= 1'b0;
      blank_q <= 1'b0;
    end else if (fs_i) begin
      case (state_q)
        ST_HIDDEN: begin
          if (title_en_i) begin
            state_q <= ST_SHOW;
            cnt_q   <= '0;
            show_q  <= 1'b1;
            blank_q <= 1'b0;
          end
        end
        ST_SHOW: begin
          if (!title_en_i) begin
            state_q <= ST_HIDDEN;
            show_q  <= 1'b0;
            blank_q <= 1'b0;
          end else if (BLINK_FRAMES != 0) begin
            if (cnt_q == LAST) begin
              state_q <= ST_BLANK;
              cnt_q   <= '0;
              show_q  <= 1'b0;
              blank_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_BLANK: begin
          if (!title_en_i) begin
            state_q <= ST_HIDDEN;
            show_q  <= 1'b0;
            blank_q <= 1'b0;
          end else if (cnt_q == LAST) begin
            state_q <= ST_SHOW;
            cnt_q   <= '0;
            show_q  <= 1'b1;
            blank_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_HIDDEN;
          cnt_q   <= '0;
          show_q  <= 1'b0;
          blank_q <= 1'b0;
        end
      endcase
    end
  end

  assign show_o  = show_q;
  assign blank_o = blank_q;

endmodule

// File: rtl/title_renderer.sv
// Title bitmap reader: maps VGA coordinates to ROM rows, picks the column
// bit and produces a registered RRRGGGBB pixel, 2 pixel ticks after the
// coordinates. Visibility/blinking comes from title_blink_fsm.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of title_renderer_if (coords, title_en, rom
//                data in; rom_addr, rgb, title_pix, blank_phase out)
module title_renderer
  import vga_pkg::*;
#(
  parameter int unsigned      X0           = 212,
  parameter int unsigned      Y0           = 100,
  parameter int unsigned      TITLE_W      = 216,
  parameter int unsigned      TITLE_H      = 36,
  parameter int unsigned      BLINK_FRAMES = 30,
  parameter logic [RGB_W-1:0] FG_COLOR     = YELLOW,
  parameter logic [RGB_W-1:0] BG_COLOR     = BLACK
) (
  input  logic              clk,
  input  logic              rst_n,
  title_renderer_if.slave   bus
);

  logic              in_box_c;
  logic              fs_c;
  logic              show_c;
  logic              blank_c;
  logic [ROW_AW-1:0] row_c;
  logic [COL_W-1:0]  col_c;
  logic [COL_W-1:0]  bit_idx_c;
  logic              pix_bit_c;

  logic [ROW_AW-1:0] rom_addr_q;
  logic [COL_W-1:0]  col_q;
  logic              in_box_q;
  logic              video_on_q;
  logic [RGB_W-1:0]  rgb_q;
  logic              title_pix_q;

  // Title box hit test; the box lies inside the visible area.
  assign in_box_c = bus.video_on
                 && (bus.pixel_x <  PX_W'(H_VISIBLE))
                 && (bus.pixel_y <  PX_W'(V_VISIBLE))
                 && (bus.pixel_x >= PX_W'(X0)) && (bus.pixel_x < PX_W'(X0 + TITLE_W))
                 && (bus.pixel_y >= PX_W'(Y0)) && (bus.pixel_y < PX_W'(Y0 + TITLE_H));

  // Offsets only used when in_box_c, so the subtraction never underflows.
  assign row_c = ROW_AW'(bus.pixel_y - PX_W'(Y0));
  assign col_c = COL_W'(bus.pixel_x - PX_W'(X0));

  // Bit 215 of the ROM word is the leftmost column.
  assign bit_idx_c = COL_W'(ROM_W - 1) - col_q;
  assign pix_bit_c = bus.rom_data[bit_idx_c];

  assign fs_c = bus.pixel_tick && (bus.pixel_x == '0) && (bus.pixel_y == '0);

  title_blink_fsm #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk        (clk),
    .rst_n      (rst_n),
    .fs_i       (fs_c),
    .title_en_i (bus.title_en),
    .show_o     (show_c),
    .blank_o    (blank_c)
  );

  // Two-stage pixel pipeline, advancing on pixel_tick only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q  <= '0;
      col_q       <= '0;
      in_box_q    <= 1'b0;
      video_on_q  <= 1'b0;
      rgb_q       <= '0;
      title_pix_q <= 1'b0;
    end else if (bus.pixel_tick) begin
      rom_addr_q <= in_box_c ? row_c : '0;
      col_q      <= in_box_c ? col_c : '0;
      in_box_q   <= in_box_c;
      video_on_q <= bus.video_on;
      if (!video_on_q) begin
        rgb_q       <= '0;
        title_pix_q <= 1'b0;
      end else if (in_box_q && pix_bit_c && show_c) begin
        rgb_q       <= FG_COLOR;
        title_pix_q <= 1'b1;
      end else begin
        rgb_q       <= BG_COLOR;
        title_pix_q <= 1'b0;
      end
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.rgb         = rgb_q;
  assign bus.title_pix   = title_pix_q;
  assign bus.blank_phase = blank_c;

endmodule

// File: tb/tb_title_renderer.sv
// Bench for title_renderer: random ROM contents and coordinates, a
// frame-level reference model, a per-cycle compare process and a few
// directed literal checks.
module tb_title_renderer;
  import vga_pkg::*;

  localparam int X0 = 212;
  localparam int Y0 = 100;
  localparam int TW = 216;
  localparam int TH = 36;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  title_renderer_if bus();

  title_renderer #(
    .X0(X0), .Y0(Y0), .TITLE_W(TW), .TITLE_H(TH),
    .BLINK_FRAMES(BF), .FG_COLOR(8'hFC), .BG_COLOR(8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational ROM
  logic [215:0] rom [64];
  assign bus.rom_data = rom[bus.rom_addr];

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 hidden, 1 show, 2 blank
  int         m_mode = 0;
  int         m_cnt  = 0;
  bit         m_pv   = 0;
  bit         m_pin  = 0;
  int         m_px   = 0;
  int         m_py   = 0;
  logic [7:0] e_rgb  = 8'h00;
  bit         e_tp   = 0;
  bit         e_blank = 0;
  logic [5:0] e_addr = 6'd0;

  function automatic bit bmp(input int row, input int col);
    logic [215:0] w;
    w = rom[row];
    return w[215 - col];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_pv = 0; m_pin = 0;
      e_rgb = 8'h00; e_tp = 0; e_blank = 0; e_addr = 6'd0;
    end else if (bus.pixel_tick) begin
      int x, y;
      bit inb;
      // pixel from the previous tick, rendered with the current mode
      e_rgb = 8'h00; e_tp = 0;
      if (m_pv) begin
        if (m_pin && m_mode == 1 && bmp(m_py - Y0, m_px - X0)) begin
          e_rgb = 8'hFC; e_tp = 1;
        end
      end
      x = int'(bus.pixel_x);
      y = int'(bus.pixel_y);
      inb = bus.video_on && x >= X0 && x < X0 + TW && y >= Y0 && y < Y0 + TH;
      m_pv = bus.video_on; m_pin = inb; m_px = x; m_py = y;
      e_addr = inb ? 6'(y - Y0) : 6'd0;
      if (x == 0 && y == 0) begin
        if (!bus.title_en) m_mode = 0;
        else if (m_mode == 0) begin m_mode = 1; m_cnt = 0; end
        else if (BF > 0 && m_cnt == BF - 1) begin m_mode = 3 - m_mode; m_cnt = 0; end
        else if (BF > 0) m_cnt++;
      end
      e_blank = (m_mode == 2);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_rom_addr", 32'(bus.rom_addr), 32'(e_addr));
      check("cyc_rgb", 32'(bus.rgb), 32'(e_rgb));
      check("cyc_title_pix", 32'(bus.title_pix), 32'(e_tp));
      check("cyc_blank_phase", 32'(bus.blank_phase), 32'(e_blank));
    end
  end

  // Present one coordinate set for one clock; returns 1 time unit after the edge.
  task automatic step(input int x, input int y, input bit v, input bit t);
    bus.pixel_x    = 10'(x);
    bus.pixel_y    = 10'(y);
    bus.video_on   = v;
    bus.pixel_tick = t;
    @(posedge clk);
    #1;
    bus.pixel_tick = 1'b0;
  endtask

  task automatic rand_step();
    int x, y;
    do begin
      if ($urandom_range(0, 1) == 1) begin
        x = $urandom_range(X0 - 4, X0 + TW + 3);
        y = $urandom_range(Y0 - 2, Y0 + TH + 1);
      end else begin
        x = $urandom_range(0, 799);
        y = $urandom_range(0, 524);
      end
    end while (x == 0 && y == 0);
    step(x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 4) != 0);
  endtask

  task automatic run_frame(input int n);
    step(0, 0, 1'b1, 1'b1);
    for (int i = 0; i < n; i++) rand_step();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.pixel_tick = 1'b0; bus.video_on = 1'b0;
    bus.pixel_x = '0; bus.pixel_y = '0; bus.title_en = 1'b0;
    for (int r = 0; r < 64; r++)
      for (int b = 0; b < 216; b++) rom[r][b] = 1'($urandom_range(0, 1));
    rom[0][215] = 1'b1;   // (212,100)
    rom[8][211] = 1'b1;   // (216,108), col 4
    rom[8][199] = 1'b0;   // (228,108), col 16
    #2 cmp_en = 1'b1;
    @(posedge clk); #1;

    // reset held with random coordinates
    for (int i = 0; i < 6; i++) begin
      step($urandom_range(X0, X0 + TW - 1), $urandom_range(Y0, Y0 + TH - 1), 1'b1, 1'b1);
      check("rst_rgb", 32'(bus.rgb), 32'h0);
      check("rst_title_pix", 32'(bus.title_pix), 32'h0);
      check("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
    end
    rst_n = 1'b1;
    bus.title_en = 1'b1;
    step(0, 0, 1'b1, 1'b1);                      // fs #0 -> SHOW
    check("fs0_blank", 32'(bus.blank_phase), 32'h0);

    step(212, 100, 1'b1, 1'b1);
    check("p212_addr", 32'(bus.rom_addr), 32'd0);
    step(216, 108, 1'b1, 1'b1);
    check("p216_addr", 32'(bus.rom_addr), 32'd8);
    check("p212_rgb", 32'(bus.rgb), 32'hFC);
    check("p212_tp", 32'(bus.title_pix), 32'h1);
    step(228, 108, 1'b1, 1'b1);
    check("p216_rgb", 32'(bus.rgb), 32'hFC);
    step(211, 100, 1'b1, 1'b1);
    check("p211_addr", 32'(bus.rom_addr), 32'd0);
    check("p228_rgb", 32'(bus.rgb), 32'h00);
    check("p228_tp", 32'(bus.title_pix), 32'h0);
    step(428, 100, 1'b1, 1'b1);
    check("p428_addr", 32'(bus.rom_addr), 32'd0);
    check("p211_rgb", 32'(bus.rgb), 32'h00);
    step(212, 100, 1'b0, 1'b1);                  // in box, video off
    check("voff_addr", 32'(bus.rom_addr), 32'd0);
    check("p428_rgb", 32'(bus.rgb), 32'h00);
    step(212, 100, 1'b1, 1'b1);
    check("voff_rgb", 32'(bus.rgb), 32'h00);
    step(300, 110, 1'b1, 1'b1);
    check("p300_addr", 32'(bus.rom_addr), 32'd10);
    check("von_rgb", 32'(bus.rgb), 32'hFC);

    // no pixel_tick: everything holds
    for (int i = 0; i < 3; i++) begin
      step(X0 + i * 7, Y0 + 3 + i, 1'b1, 1'b0);
      check("hold_addr", 32'(bus.rom_addr), 32'd10);
      check("hold_rgb", 32'(bus.rgb), 32'hFC);
    end

    // blinking with BLINK_FRAMES=2
    run_frame(20);                               // fs #1
    step(0, 0, 1'b1, 1'b1);                      // fs #2 -> BLANK
    check("fs2_blank", 32'(bus.blank_phase), 32'h1);
    step(212, 100, 1'b1, 1'b1);
    step(300, 110, 1'b1, 1'b1);
    check("blank_fg_rgb", 32'(bus.rgb), 32'h00);
    run_frame(20);                               // fs #3
    step(0, 0, 1'b1, 1'b1);                      // fs #4 -> SHOW
    check("fs4_blank", 32'(bus.blank_phase), 32'h0);
    step(212, 100, 1'b1, 1'b1);
    step(300, 110, 1'b1, 1'b1);
    check("show_fg_rgb", 32'(bus.rgb), 32'hFC);

    // asynchronous reset mid-frame
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rgb", 32'(bus.rgb), 32'h0);
    check("async_rst_tp", 32'(bus.title_pix), 32'h0);
    check("async_rst_addr", 32'(bus.rom_addr), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(212, 100, 1'b1, 1'b1);
    step(300, 110, 1'b1, 1'b1);
    check("hidden_after_rst", 32'(bus.rgb), 32'h00);
    step(0, 0, 1'b1, 1'b1);                      // back to SHOW
    step(212, 100, 1'b1, 1'b1);
    step(300, 110, 1'b1, 1'b1);
    check("reshow_rgb", 32'(bus.rgb), 32'hFC);

    // disable mid-frame takes effect at the next frame start
    bus.title_en = 1'b0;
    step(212, 100, 1'b1, 1'b1);
    step(300, 110, 1'b1, 1'b1);
    check("en_off_mid_rgb", 32'(bus.rgb), 32'hFC);
    step(0, 0, 1'b1, 1'b1);
    step(212, 100, 1'b1, 1'b1);
    step(300, 110, 1'b1, 1'b1);
    check("hidden_rgb", 32'(bus.rgb), 32'h00);
    check("hidden_blank", 32'(bus.blank_phase), 32'h0);

    // random frames with random enable changes
    for (int f = 0; f < 40; f++) begin
      bus.title_en = ($urandom_range(0, 4) != 0);
      run_frame($urandom_range(20, 120));
      if ($urandom_range(0, 3) == 0) bus.title_en = ~bus.title_en;
      for (int i = 0; i < 30; i++) rand_step();
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/title_renderer.md
Name: title_renderer

Overview:
- Reader side of the 216x36 title bitmap ROM (6-bit row address in, 216-bit row word out, bit 215 = leftmost column).
- Takes VGA pixel coordinates from the sync generator and issues registered row addresses to the ROM.
- Selects the current column bit and produces a registered 8-bit RRRGGGBB pixel.
- Shows the title only when enabled, with optional frame-synchronous blinking; sits between vga_sync and the top-level colour mux.

Parameters:
- X0, 212, left screen column of the title box (10 bit)
- Y0, 100, top screen row of the title box (10 bit)
- TITLE_W, 216, bitmap width in pixels
- TITLE_H, 36, bitmap height in rows
- BLINK_FRAMES, 30, frames per show/blank phase; 0 disables blinking
- FG_COLOR, 8'hFC, colour of a set bitmap bit
- BG_COLOR, 8'h00, colour of a clear bit and of pixels outside the box

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pixel_tick  in  1  one-cycle pixel enable from vga_sync
- video_on  in  1  visible-area flag for pixel_x/pixel_y
- pixel_x  in  10  current column, 0..799
- pixel_y  in  10  current row, 0..524
- title_en  in  1  level request to display the title
- rom_addr  out  6  registered ROM row address
- rom_data  in  216  ROM row word; combinational ROM, valid the cycle after rom_addr changes
- rgb  out  8  registered pixel colour
- title_pix  out  1  registered; 1 when rgb carries FG_COLOR
- blank_phase  out  1  registered; 1 while the FSM is in BLANK

Behaviour:
- Reset (async, rst_n=0): rom_addr=0, rgb=0, title_pix=0, blank_phase=0, FSM=HIDDEN, frame counter=0, all pipeline registers cleared.
- All state advances only on cycles with pixel_tick=1. Between ticks, every register holds.
- Stage 1 (tick n):
  - in_box = video_on && X0<=pixel_x<X0+TITLE_W && Y0<=pixel_y<Y0+TITLE_H.
  - col_q = pixel_x-X0 (8 bit).
  - rom_addr = in_box ? pixel_y-Y0 : 0.
  - Register in_box and video_on.
- Stage 2 (tick n+1):
  - bit = rom_data[215-col_q].
  - If video_on_q=0: rgb=0, title_pix=0.
  - Else if in_box_q && bit && state==SHOW: rgb=FG_COLOR, title_pix=1.
  - Otherwise: rgb=BG_COLOR, title_pix=0.
- Latency: exactly 2 pixel_ticks from coordinates to rgb. The top level delays hsync/vsync by 2 ticks.
- Differences are computed only when in_box is true, so there is no underflow; out-of-box addresses are forced to 0.
- Frame start (fs) = pixel_tick && pixel_x==0 && pixel_y==0.
- FSM (states HIDDEN, SHOW, BLANK) changes state only at fs, so a frame is never torn:
  - HIDDEN: at fs with title_en=1, go to SHOW and clear the counter.
  - SHOW: at fs with title_en=0, go to HIDDEN. Else, if BLINK_FRAMES>0 and counter==BLINK_FRAMES-1, go to BLANK and clear the counter. Else counter++.
  - BLANK: at fs with title_en=0, go to HIDDEN. Else, if counter==BLINK_FRAMES-1, go to SHOW and clear the counter. Else counter++.
  - title_en=0 has priority over a phase change at the same fs.
  - With BLINK_FRAMES=0 the FSM never enters BLANK and the counter stays 0.
  - The counter is wide enough for BLINK_FRAMES-1 (clog2, minimum 1 bit).
- blank_phase = (state==BLANK), registered.
- Reset mid-frame: outputs drop to reset values immediately. The title is hidden until the next fs with title_en=1.

Decomposition:
- Shared package vga_pkg: H_VISIBLE=640, V_VISIBLE=480, 8-bit colour constants (BLACK, YELLOW=8'hFC), title FSM state encoding.
- One sub-module, title_blink_fsm: holds the FSM and frame counter. Inputs fs and title_en; output show. The pixel pipeline stays in title_renderer.

Test Plan:
- Reset held, random coordinates -> rgb=0, title_pix=0, rom_addr=0; release reset, title_en=1, one fs -> state SHOW.
- Pixel (212,100) driven, ROM row 0 bit 215=1 -> rom_addr=0 after 1 tick; rgb=8'hFC, title_pix=1 after 2 ticks.
- Pixel (216,108), row 8: col 4 bit=1 gives FG, and (228,108), col 16 bit=0 gives 8'h00; pixel (211,100) and (428,100) -> 8'h00 with rom_addr held at 0.
- video_on=0 with in-box coordinates -> rgb=0 two ticks later.
- BLINK_FRAMES=2, title_en=1:
  - fs #0 enters SHOW.
  - After fs #2: BLANK (blank_phase=1, in-box FG pixels render 8'h00).
  - After fs #4: SHOW.
  - title_en=0 mid-frame -> no change until the next fs, then HIDDEN.
- pixel_tick held low for 3 cycles with changing coordinates -> rgb and rom_addr unchanged; rst_n pulsed mid-frame -> outputs 0 asynchronously.
